// File: rtl/logic_reduce_acc_if.sv
// Stream interface for logic_reduce_acc: input beat channel plus frame-result channel.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry the valid-ready handshakes.
// Ports (signals): in_valid/in_ready/in_data/in_last/op (beat side),
//   out_valid/out_ready/out_data/out_beats/out_err (result side),
//   out_parity only when LOGIC_REDUCE_ACC_PARITY_EN is defined.
// master = producer/consumer side, slave = the reduce block.
interface logic_reduce_acc_if #(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int CW = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_last;
    logic [2:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_beats;
    logic           out_err;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
    logic           out_parity;
`endif

    modport master (
        output in_valid, in_data, in_last, op, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_err
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, op, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_err
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/logic_reduce_acc.sv
// Bitwise N-channel logic reduction of beats, accumulated over a frame ending on in_last.
// Latency: result valid the cycle after the in_last beat transfer.
// Backpressure: in_ready drops while a result waits in OUT; result held until out_ready.
// Ports: clk, rst (synchronous, active-high); bus (logic_reduce_acc_if.slave) carries
//   the beat stream (in_*, op) and the frame result (out_data, out_beats, out_err).
// Optional: define LOGIC_REDUCE_ACC_PARITY_EN to add out_parity (XOR-reduce of out_data).
module logic_reduce_acc #(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_reduce_acc_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [1:0]    B_AND   = 2'd0;
    localparam logic [1:0]    B_OR    = 2'd1;
    localparam logic [1:0]    B_XOR   = 2'd2;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t         state_q;
    state_t         state_d;
    logic [2:0]     op_q;
    logic [2:0]     cur_op;
    logic [1:0]     base;
    logic           illegal;
    logic           invert;
    logic [W-1:0]   beat_red;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   res_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           in_ready_w;
    logic           out_valid_w;
    logic           in_xfer;
    logic [W-1:0]   out_data_q;
    logic [CW-1:0]  out_beats_q;
    logic           out_err_q;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
    logic           out_parity_q;
`endif

    function automatic logic [W-1:0] combine(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0]   bop);
        case (bop)
            B_AND:   combine = a & b;
            B_OR:    combine = a | b;
            default: combine = a ^ b;
        endcase
    endfunction

    // The op port only matters on the first beat; op_q governs the rest of the frame.
    always_comb begin
        cur_op  = (state_q == IDLE) ? bus.op : op_q;
        illegal = (cur_op > 3'd5);
        invert  = (cur_op >= 3'd3) && (cur_op <= 3'd5);
        case (cur_op)
            3'd0, 3'd3: base = B_AND;
            3'd1, 3'd4: base = B_OR;
            3'd2, 3'd5: base = B_XOR;
            default:    base = B_OR;
        endcase
    end

    always_comb begin
        beat_red = bus.in_data[W-1:0];
        for (int k = 1; k < N; k++) begin
            beat_red = combine(beat_red, bus.in_data[k*W +: W], base);
        end
    end

    // Inversion is applied once to the finished accumulator, never per beat,
    // so NAND/NOR/XNOR frames accumulate with the plain base op.
    always_comb begin
        acc_d = (state_q == IDLE) ? beat_red : combine(acc_q, beat_red, base);
        if (state_q == IDLE) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (illegal) begin
            res_d = '0;
        end else if (invert) begin
            res_d = ~acc_d;
        end else begin
            res_d = acc_d;
        end
    end

    assign in_xfer = bus.in_valid && in_ready_w;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_xfer) state_d = bus.in_last ? OUT : ACC;
            ACC:  if (in_xfer && bus.in_last) state_d = OUT;
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; both handshakes depend only on state and rst.
    always_comb begin
        in_ready_w  = !rst && (state_q != OUT);
        out_valid_w = !rst && (state_q == OUT);
    end

    // Datapath: accumulator, beat counter and the registered frame result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_err_q   <= 1'b0;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else if (in_xfer) begin
            if (state_q == IDLE) begin
                op_q <= bus.op;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (bus.in_last) begin
                out_data_q  <= res_d;
                out_beats_q <= cnt_d;
                out_err_q   <= illegal;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
                out_parity_q <= ^res_d;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_err   = out_err_q;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: doc/logic_reduce_acc.md
Name: logic_reduce_acc

Overview:
- Parametrised, registered successor to the two-input combinational logic gates.
- Accepts beats of N channels of W bits each over a valid/ready stream.
- Reduces each beat bitwise with a selectable logic op (AND/OR/XOR and their inversions) and accumulates the result across a multi-beat frame delimited by in_last.
- Emits one W-bit result per frame on a valid/ready output. Sits between stream producers and status/flag logic, e.g. sticky-OR error aggregation or parity/mask folding.

Parameters:
- W, 8, data width per channel (>=1)
- N, 2, channels per input beat (>=2)
- CW, 16, width of the beat counter out_beats (>=1)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  N*W  channel k occupies bits [k*W+W-1 : k*W]
- in_last  in  1  beat is the final beat of the frame
- op  in  3  0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR, 6/7 illegal
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  W  frame result
- out_beats  out  CW  beats in the frame, saturating at 2^CW-1
- out_err  out  1  frame was started with an illegal op

Behaviour:
- Reset: the state machine goes to IDLE and the partial accumulator is discarded. out_valid=0, out_data=0, out_beats=0, out_err=0. in_ready=0 while rst is high.
- Beat transfer: occurs on a clock edge where in_valid && in_ready. Output transfer: occurs on an edge where out_valid && out_ready.
- State IDLE (no beat of the current frame taken), in_ready=1:
  - Transfer latches op into op_q.
  - Sets acc = beat reduction and cnt = 1.
  - Goes to OUT if in_last=1, else to ACC.
- State ACC, in_ready=1:
  - Transfer updates acc = acc <base op> beat reduction and cnt = min(cnt+1, 2^CW-1).
  - Goes to OUT if in_last=1.
  - The op port is ignored in ACC; op_q governs the whole frame.
- State OUT, in_ready=0, out_valid=1:
  - out_data, out_beats and out_err are registered and held stable until transfer.
  - On transfer, goes to IDLE, so in_ready=1 the next cycle. This is a one-cycle input bubble per frame; a full throughput of one frame per two cycles is acceptable.
- Beat reduction: bitwise across all N channels using the base op. Base op is AND for codes 0/3, OR for 1/4, XOR for 2/5.
- Inversion for NAND/NOR/XNOR is applied once, to the final acc, when entering OUT; it is never applied per beat.
- Illegal op (6/7) latched at frame start: beats are still consumed normally and the frame completes on in_last. The result is out_data=0 and out_err=1.
- Latency: out_valid rises on the edge after the in_last beat transfer, and out_data is valid in the same cycle.
- in_valid=0 in ACC: state holds indefinitely; no timeout.
- Reset mid-frame: the partial frame is dropped silently with no output; the next frame starts clean.
- out_valid in OUT does not depend on in_valid. The output handshake has no combinational path from in_* to out_*.

Optional Feature:
- Macro LOGIC_REDUCE_ACC_PARITY_EN.
- When defined, adds port out_parity (out, 1). It equals the XOR-reduction of out_data, is registered with out_data, is 0 on reset, and is held stable in OUT.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan (W=8, N=2, in_data = {ch1, ch0}):
- OR single beat: {8'h0F, 8'hF0}, op=1, last=1 -> next cycle out_valid=1, out_data=8'hFF, out_beats=1, out_err=0.
- AND 3 beats: {FF,F0}, {3C,FF}, {F3,FF}, last on the 3rd, op=0 -> out_data=8'h30, out_beats=3. Driving op=1 on beats 2-3 leaves the result unchanged.
- XNOR 2 beats: {AA,55}, {0F,00}, op=5 -> out_data=8'h0F. NAND single beat {FF,FF} -> out_data=8'h00.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid=1, out_data stable, in_ready=0 throughout. Raise out_ready -> transfer occurs, in_ready=1 on the next cycle, out_valid=0.
- Illegal op 6 over 2 beats -> out_err=1, out_data=8'h00, out_beats=2. The next frame with op=1 -> out_err=0.
- Reset mid-frame: 2 beats of OR with no last, then rst for 1 cycle -> all outputs 0 and in_ready=0 during reset. A following single OR beat {01,02} last -> out_data=8'h03, out_beats=1. With LOGIC_REDUCE_ACC_PARITY_EN defined, out_parity=0.
